// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte sources
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8,
  parameter int TW            = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_par_en,
  input  logic [NUM_REQ-1:0]   req_par_typ,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           p_data,
  output logic                 data_valid,
  output logic                 par_en,
  output logic                 par_typ,
  input  logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 arb_busy,
  output logic                 launch_err
);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT_START = 2'd2, WAIT_END = 2'd3;
  logic [1:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d, grant_id_q, grant_id_d, sel, cand;
  logic found;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0] p_data_q, p_data_d, ack_x, req_x, pen_x, ptyp_x;
  logic [7:0] data_a [8];
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, dv_q, dv_d, err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  assign req_x  = 8'(req);
  assign pen_x  = 8'(req_par_en);
  assign ptyp_x = 8'(req_par_typ);
  for (genvar i = 0; i < 8; i++) begin : g_pad
    if (i < NUM_REQ) begin : g_on
      assign data_a[i] = req_data[8*i +: 8];
    end else begin : g_off
      assign data_a[i] = '0;
    end
  end
  always_comb begin
    sel = '0;
    cand = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = 3'((int'(ptr_q) + k) % NUM_REQ);
      if (req_x[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    ack_x      = 8'd1 << sel;
    case (state_q)
      IDLE: if (!busy && found) begin
        state_d    = LAUNCH;
        ptr_d      = (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;
        grant_id_d = sel;
        p_data_d   = data_a[sel];
        par_en_d   = pen_x[sel];
        par_typ_d  = ptyp_x[sel];
        ack_d      = ack_x[NUM_REQ-1:0];
      end
      LAUNCH: begin
        state_d = WAIT_START;
        cnt_d   = '0;
        dv_d    = 1'b1;
      end
      WAIT_START: if (busy) state_d = WAIT_END;
        else if (cnt_q == TW'(START_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + TW'(1);
      default: if (!busy) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= '0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
    end
  end
  assign ack        = ack_q;
  assign p_data     = p_data_q;
  assign data_valid = dv_q;
  assign par_en     = par_en_q;
  assign par_typ    = par_typ_q;
  assign grant_id   = grant_id_q;
  assign arb_busy   = state_q != IDLE;
  assign launch_err = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench with a round-robin reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, TO = 8, TW = 4;
  logic clk = 1'b0, rst = 1'b1, busy = 1'b0;
  logic [N-1:0] req = '0, req_par_en = '0, req_par_typ = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic [7:0] p_data;
  logic data_valid, par_en, par_typ, arb_busy, launch_err;
  logic [2:0] grant_id;
  typedef struct {int id; logic [7:0] d; logic pe; logic pt;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int err_q[$];
  int checks = 0, errors = 0, cyc = 0, m_ptr = 0;
  int ack_cyc = -10, ack_n = 0, dv_n = 0;
  int bz_delay = -1, bz_hold = 0, f_delay = -1, f_hold = 0;
  bit drop_next = 0, rand_drop = 0;
  logic [N-1:0] req_e = '0;
  logic busy_e = 1'b0;
  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_par_en(req_par_en),
    .req_par_typ(req_par_typ), .ack(ack), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .busy(busy), .grant_id(grant_id),
    .arb_busy(arb_busy), .launch_err(launch_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    req_e = req;
    busy_e = busy;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, want, cyc);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (ack != '0) begin
      ack_n++;
      ack_cyc = cyc;
      chk("ack_onehot", 32'($onehot(ack)), 1);
      chk("ack_req_high", 32'(|(ack & req_e)), 1);
      chk("ack_busy_low", 32'(busy_e), 0);
      if (exp_q.size() == 0) chk("ack_unexpected", 32'(ack), 0);
      else begin
        e = exp_q.pop_front();
        chk("ack_id", 32'(ack), 32'(1) << e.id);
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("p_data", 32'(p_data), 32'(e.d));
        chk("par_en", 32'(par_en), 32'(e.pe));
        chk("par_typ", 32'(par_typ), 32'(e.pt));
      end
    end
    if (data_valid) begin
      dv_n++;
      chk("dv_latency", 32'(cyc - ack_cyc), 1);
    end
    if (launch_err) begin
      if (err_q.size() == 0) chk("err_unexpected", 1, 0);
      else chk("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
    end
  end
  task automatic step();
    @(negedge clk);
    req = req & ~ack;
    if (data_valid) begin
      if (drop_next || (rand_drop && $urandom_range(0, 5) == 0)) begin
        err_q.push_back(cyc + TO + 1);
        drop_next = 0;
      end else bz_delay = (f_delay >= 0) ? f_delay : int'($urandom_range(0, 3));
    end
    if (bz_delay == 0) begin
      busy = 1'b1;
      bz_hold = (f_hold > 0) ? f_hold : int'($urandom_range(1, 12));
      bz_delay = -1;
    end else if (bz_delay > 0) bz_delay--;
    else if (bz_hold > 0) begin
      bz_hold--;
      if (bz_hold == 0) busy = 1'b0;
    end
  endtask
  task automatic issue(input logic [N-1:0] m, input int mode);
    int last = 0;
    for (int i = 0; i < N; i++) if (m[i]) begin
      req_data[8*i +: 8] = (mode == 1) ? 8'(8'h10 + i) : (mode == 2) ? 8'hA5 : 8'($urandom);
      req_par_en[i] = (mode == 2) ? 1'b1 : 1'($urandom);
      req_par_typ[i] = (mode == 2) ? 1'b1 : 1'($urandom);
    end
    for (int k = 0; k < N; k++) begin
      int id = (m_ptr + k) % N;
      if (m[id]) begin
        exp_q.push_back(exp_t'{id, req_data[8*id +: 8], req_par_en[id], req_par_typ[id]});
        last = id;
      end
    end
    m_ptr = (last + 1) % N;
    req = req | m;
  endtask
  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (req == '0 && !arb_busy && !busy && exp_q.size() == 0 && err_q.size() == 0 && bz_delay < 0) return;
      step();
    end
    chk("drain_timeout", 1, 0);
  endtask
  task automatic wait_busy(input logic v);
    for (int i = 0; i < 100; i++) begin
      if (busy === v) return;
      step();
    end
    chk("busy_wait_timeout", 1, 0);
  endtask
  task automatic check_zero(input string nm);
    chk({nm, "_ack"}, 32'(ack), 0);
    chk({nm, "_p_data"}, 32'(p_data), 0);
    chk({nm, "_dv"}, 32'(data_valid), 0);
    chk({nm, "_par_en"}, 32'(par_en), 0);
    chk({nm, "_par_typ"}, 32'(par_typ), 0);
    chk({nm, "_grant_id"}, 32'(grant_id), 0);
    chk({nm, "_arb_busy"}, 32'(arb_busy), 0);
    chk({nm, "_launch_err"}, 32'(launch_err), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    busy = 1'b0;
    bz_delay = -1;
    bz_hold = 0;
    step();
    check_zero("reset");
    step();
    rst = 1'b0;
    m_ptr = 0;
  endtask
  initial begin
    do_reset();
    f_delay = 1;
    f_hold = 11;
    issue(4'b0010, 2);
    wait_busy(1'b1);
    wait_busy(1'b0);
    chk("arb_busy_before_idle", 32'(arb_busy), 1);
    step();
    chk("arb_busy_after_frame", 32'(arb_busy), 0);
    f_delay = -1;
    f_hold = 0;
    drain();
    do_reset();
    issue(4'b1111, 1);
    drain();
    issue(4'b0001, 1);
    drain();
    issue(4'b0100, 1);
    drain();
    issue(4'b0101, 1);
    drain();
    drop_next = 1;
    issue(4'b1010, 0);
    drain();
    busy = 1'b1;
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
    m_ptr = 0;
    issue(4'b0001, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_ack_while_busy", 32'(ack), 0);
    end
    busy = 1'b0;
    step();
    chk("ack_after_busy_low", 32'(ack), 1);
    drain();
    f_delay = 0;
    f_hold = 12;
    issue(4'b0001, 0);
    wait_busy(1'b1);
    step();
    step();
    chk("mid_frame_arb_busy", 32'(arb_busy), 1);
    rst = 1'b1;
    busy = 1'b0;
    bz_hold = 0;
    step();
    check_zero("midrst");
    rst = 1'b0;
    m_ptr = 0;
    f_delay = -1;
    f_hold = 0;
    issue(4'b1000, 0);
    drain();
    rand_drop = 1;
    for (int b = 0; b < 40; b++) begin
      issue(4'($urandom_range(1, 15)), 0);
      drain();
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) step();
    end
    drain();
    chk("dv_vs_ack", 32'(dv_n), 32'(ack_n));
    chk("exp_empty", 32'(exp_q.size()), 0);
    chk("err_empty", 32'(err_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter among NUM_REQ byte sources. It selects a requester and latches that requester's byte and parity configuration. It drives the transmitter's parallel-data, data-valid and parity-config inputs, then tracks the transmitter's busy flag until the frame completes. It sits between the byte producers (command/status/debug engines) and the UART TX top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 8, max cycles to wait for busy to rise after data_valid before declaring a launch fault
TW, 4, width of the timeout counter (must hold START_TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester byte-pending request, level, held until ack
req_data  in  8*NUM_REQ  flattened bytes, requester i at [8i+7:8i]
req_par_en  in  NUM_REQ  per-requester parity enable
req_par_typ  in  NUM_REQ  per-requester parity type (0 even, 1 odd)
ack  out  NUM_REQ  one-hot, one-cycle pulse: requester's byte accepted
p_data  out  8  byte to transmitter
data_valid  out  1  one-cycle launch strobe to transmitter
par_en  out  1  parity enable to transmitter
par_typ  out  1  parity type to transmitter
busy  in  1  transmitter busy flag
grant_id  out  3  index of current/last granted requester
arb_busy  out  1  high whenever state is not IDLE
launch_err  out  1  one-cycle pulse on start timeout

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; ack=0, p_data=0, data_valid=0, par_en=0, par_typ=0, grant_id=0, arb_busy=0, launch_err=0; the round-robin pointer is set so requester 0 has highest priority. Reset mid-frame abandons the transaction with no ack; any frame already on the line is not the arbiter's concern.
- States: IDLE, LAUNCH, WAIT_START, WAIT_END.
- IDLE: if busy=0 and req!=0, pick the first set req bit at or after ptr, scanning upward with wrap-around. Latch that requester's req_data, req_par_en and req_par_typ into p_data, par_en and par_typ. Set grant_id. Pulse ack[sel] in the same cycle the latch registers. Set ptr=sel+1 mod NUM_REQ. Go to LAUNCH. If busy=1 (e.g. a transmitter frame left from before reset), stay in IDLE and grant nothing.
- LAUNCH: data_valid=1 for exactly this one cycle; clear the timeout counter; go to WAIT_START.
- WAIT_START: if busy=1, go to WAIT_END. Otherwise increment the counter; when the counter reaches START_TIMEOUT, pulse launch_err and go to IDLE. The byte is not retried and ack has already been given.
- WAIT_END: wait for busy=0, then go to IDLE. The next grant can occur no earlier than the following cycle, so busy must be sampled low in IDLE.
- p_data, par_en and par_typ are held stable from the latch until the next grant. Requesters may change req_data after ack.
- Latency: req seen in IDLE -> ack and registered outputs 1 cycle later -> data_valid 1 cycle after that. Back-to-back frames have at least 1 IDLE cycle between busy falling and the next ack.
- A req deasserted before it is granted is simply not selected. A requester whose req is still high after its ack is treated as a new byte and competes again under round-robin.
- ack is never asserted for a requester whose req bit is 0 in the selection cycle.
- Only one ack bit is high per cycle; at most one ack per transaction.
- grant_id uses the low bits of the index; unused upper bits are 0.

Test Plan:
- Single request: req=4'b0010, req_data[15:8]=8'hA5, par_en=1, par_typ=1; busy model rises 1 cycle after data_valid and holds 11 cycles -> ack=4'b0010 pulse, p_data=A5, par_en=1, par_typ=1, a single data_valid pulse, grant_id=1, arb_busy low again 1 cycle after busy falls.
- Round-robin fairness: req=4'b1111 held, bytes 10/11/12/13 -> grant order 0,1,2,3,0 with matching p_data; no requester is granted twice before the others.
- Wrap-around: ptr at 3 after granting 2; req=4'b0101 -> requester 0 is granted next, then 2.
- Start timeout: busy held 0 after data_valid -> launch_err pulses exactly START_TIMEOUT+1 cycles after data_valid, state returns to IDLE, next pending req is granted normally.
- Busy already high: busy=1 from before reset, req=4'b0001 -> no ack while busy=1; ack occurs the cycle after busy is sampled low in IDLE.
- Reset mid-frame: assert rst during WAIT_END -> next cycle all outputs are at reset values; after rst drops with busy=0 and req=4'b1000, requester 3 is granted (ptr at 0, scanning finds 3).
